// File: rtl/pipeline_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_pkg
// Description : Shared pipeline definitions. It holds the stage bundle
//               layouts, the stage-register state encoding, the bubble fill
//               value and the occupancy decode helper.
// Revision    : 1.0 - initial release
// ============================================================================
package pipeline_pkg;

    localparam int c_XLEN           = 32;
    localparam int c_REG_ADDR_WIDTH = 5;

    // Writeback select. Zero means "no writeback", so an all-zero bubble
    // retires as a no-op.
    typedef enum logic [1:0] {
        WB_SEL_NONE = 2'd0,
        WB_SEL_ALU  = 2'd1,
        WB_SEL_MEM  = 2'd2,
        WB_SEL_PC4  = 2'd3
    } wb_sel_t;

    typedef struct packed {
        logic [c_XLEN-1:0]           alu_result;
        logic [c_XLEN-1:0]           store_data;
        logic [c_XLEN-1:0]           pc_plus4;
        logic [c_REG_ADDR_WIDTH-1:0] rd;
        logic                        mem_read;
        logic                        mem_write;
        wb_sel_t                     wb_sel;
    } ex_mem_bundle_t;

    typedef struct packed {
        logic [c_XLEN-1:0]           alu_result;
        logic [c_XLEN-1:0]           mem_rdata;
        logic [c_XLEN-1:0]           pc_plus4;
        logic [c_REG_ADDR_WIDTH-1:0] rd;
        wb_sel_t                     wb_sel;
    } mem_wb_bundle_t;

    localparam int c_EX_MEM_WIDTH = $bits(ex_mem_bundle_t);
    localparam int c_MEM_WB_WIDTH = $bits(mem_wb_bundle_t);

    // Stage-register occupancy states; SKID is reachable only with a skid entry.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } stage_state_t;

    // Fill bit of a bubble; replicate to the payload width.
    localparam logic c_BUBBLE = 1'b0;

    // Number of payloads held in a given state.
    function automatic logic [1:0] state_occupancy(input stage_state_t state);
        case (state)
            FULL:    return 2'd1;
            SKID:    return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

endpackage : pipeline_pkg
`default_nettype wire

// File: rtl/pipeline_stage_register_skid_entry.sv
`default_nettype none
// ============================================================================
// Module      : stage_skid_entry
// Description : One storage entry of a pipeline stage register: a valid flag
//               plus a payload register. Clear wins over load so that a kill
//               can never be overridden by a capture in the same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module stage_skid_entry
    import pipeline_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic             i_clear,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data
);

    logic             r_valid;
    logic [WIDTH-1:0] r_data;

    // Hold the entry; a cleared entry reads back as a bubble.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_valid <= 1'b0;
            r_data  <= {WIDTH{c_BUBBLE}};
        end else if (i_clear) begin
            r_valid <= 1'b0;
            r_data  <= {WIDTH{c_BUBBLE}};
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule : stage_skid_entry
`default_nettype wire

// File: rtl/pipeline_stage_register.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_stage_register
// Description : Generic pipeline stage register with valid/ready handshake,
//               synchronous flush and an optional second (skid) entry that
//               lets in_ready be driven from a flop.
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_stage_register
    import pipeline_pkg::*;
#(
    parameter int XLEN          = 32,
    parameter int PAYLOAD_WIDTH = 3*XLEN+3,
    parameter int SKID_ENABLE   = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [PAYLOAD_WIDTH-1:0] in_payload,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [PAYLOAD_WIDTH-1:0] out_payload,
    output logic [1:0]               occupancy
);

    stage_state_t             r_state;
    stage_state_t             w_state_nxt;
    logic [1:0]               r_occupancy;

    logic                     w_xfer_in;
    logic                     w_xfer_out;

    logic                     w_main_load;
    logic                     w_main_clear;
    logic                     w_main_valid;
    logic [PAYLOAD_WIDTH-1:0] w_main_din;
    logic [PAYLOAD_WIDTH-1:0] w_main_data;

    logic                     w_skid_valid;
    logic [PAYLOAD_WIDTH-1:0] w_skid_data;

    assign w_xfer_in  = in_valid && in_ready && !flush;
    assign w_xfer_out = out_valid && out_ready;

    // The main entry is refilled from the skid entry whenever that one is
    // occupied, otherwise straight from the upstream stage.
    assign w_main_din   = w_skid_valid ? w_skid_data : in_payload;

    assign w_main_load  = !flush && (((r_state == EMPTY) && w_xfer_in)               ||
                                     ((r_state == FULL)  && w_xfer_in && w_xfer_out) ||
                                     ((r_state == SKID)  && w_xfer_out));
    assign w_main_clear = flush || ((r_state == FULL) && w_xfer_out && !w_xfer_in);

    // Next occupancy state; flush empties the stage from any state.
    always_comb begin
        w_state_nxt = r_state;
        if (flush) begin
            w_state_nxt = EMPTY;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_xfer_in) w_state_nxt = FULL;
                end
                FULL: begin
                    if (w_xfer_out && !w_xfer_in)
                        w_state_nxt = EMPTY;
                    else if (w_xfer_in && !w_xfer_out && (SKID_ENABLE != 0))
                        w_state_nxt = SKID;
                end
                SKID: begin
                    if (w_xfer_out) w_state_nxt = FULL;
                end
                default: w_state_nxt = EMPTY;
            endcase
        end
    end

    // State and occupancy advance together on the same edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= EMPTY;
            r_occupancy <= 2'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_occupancy <= state_occupancy(w_state_nxt);
        end
    end

    stage_skid_entry #(
        .WIDTH (PAYLOAD_WIDTH)
    ) u_main_entry (
        .clk     (clk),
        .reset   (reset),
        .i_load  (w_main_load),
        .i_clear (w_main_clear),
        .i_data  (w_main_din),
        .o_valid (w_main_valid),
        .o_data  (w_main_data)
    );

    if (SKID_ENABLE != 0) begin : g_skid
        logic w_skid_load;
        logic w_skid_clear;
        logic r_in_ready;

        // A payload accepted while the downstream stalls lands in the skid entry.
        assign w_skid_load  = !flush && (r_state == FULL) && w_xfer_in && !w_xfer_out;
        assign w_skid_clear = flush || ((r_state == SKID) && w_xfer_out);

        stage_skid_entry #(
            .WIDTH (PAYLOAD_WIDTH)
        ) u_skid_entry (
            .clk     (clk),
            .reset   (reset),
            .i_load  (w_skid_load),
            .i_clear (w_skid_clear),
            .i_data  (in_payload),
            .o_valid (w_skid_valid),
            .o_data  (w_skid_data)
        );

        // Ready is registered so out_ready never reaches in_ready combinationally.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                r_in_ready <= 1'b0;
            end else begin
                r_in_ready <= (w_state_nxt != SKID);
            end
        end

        assign in_ready = r_in_ready && !flush;
    end else begin : g_no_skid
        logic r_alive;

        // Keeps in_ready low during reset and for the edge that releases it.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                r_alive <= 1'b0;
            end else begin
                r_alive <= 1'b1;
            end
        end

        assign w_skid_valid = 1'b0;
        assign w_skid_data  = {PAYLOAD_WIDTH{c_BUBBLE}};
        assign in_ready     = r_alive && !flush && (!out_valid || out_ready);
    end

    assign out_valid   = w_main_valid;
    assign out_payload = w_main_data;
    assign occupancy   = r_occupancy;

endmodule : pipeline_stage_register
`default_nettype wire

// File: tb/tb_pipeline_stage_register.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_pipeline_stage_register
// Description : Directed bench for the pipeline stage register. Index 0 is
//               the single-entry stage, index 1 the skid stage.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_stage_register;

    localparam int W = 16;

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic [1:0]         flush;
    logic [1:0]         in_valid;
    logic [1:0]         in_ready;
    logic [1:0][W-1:0]  in_payload;
    logic [1:0]         out_valid;
    logic [1:0]         out_ready;
    logic [1:0][W-1:0]  out_payload;
    logic [1:0][1:0]    occupancy;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pipeline_stage_register #(.XLEN(32), .PAYLOAD_WIDTH(W), .SKID_ENABLE(0)) dut_ns (
        .clk (clk), .reset (reset), .flush (flush[0]),
        .in_valid (in_valid[0]), .in_ready (in_ready[0]), .in_payload (in_payload[0]),
        .out_valid (out_valid[0]), .out_ready (out_ready[0]), .out_payload (out_payload[0]),
        .occupancy (occupancy[0])
    );

    pipeline_stage_register #(.XLEN(32), .PAYLOAD_WIDTH(W), .SKID_ENABLE(1)) dut_sk (
        .clk (clk), .reset (reset), .flush (flush[1]),
        .in_valid (in_valid[1]), .in_ready (in_ready[1]), .in_payload (in_payload[1]),
        .out_valid (out_valid[1]), .out_ready (out_ready[1]), .out_payload (out_payload[1]),
        .occupancy (occupancy[1])
    );

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b0; flush = 2'b00; in_valid = 2'b11; out_ready = 2'b11;
        in_payload[0] = 16'h00A5; in_payload[1] = 16'h00A5;
        repeat (2) @(negedge clk);
        #1;
        for (int m = 0; m < 2; m++) begin
            checks++; if (out_valid[m] !== 1'b0) begin failures++; $display("FAIL reset_out_valid dut%0d got %b want 0", m, out_valid[m]); end
            checks++; if (out_payload[m] !== 16'h0) begin failures++; $display("FAIL reset_out_payload dut%0d got %h want 0000", m, out_payload[m]); end
            checks++; if (occupancy[m] !== 2'd0) begin failures++; $display("FAIL reset_occupancy dut%0d got %0d want 0", m, occupancy[m]); end
            checks++; if (in_ready[m] !== 1'b0) begin failures++; $display("FAIL reset_in_ready dut%0d got %b want 0", m, in_ready[m]); end
        end
        @(negedge clk);
        reset = 1'b1; in_valid = 2'b00;
        #1;
        for (int m = 0; m < 2; m++) begin
            checks++; if (in_ready[m] !== 1'b0) begin failures++; $display("FAIL release_before_edge dut%0d got %b want 0", m, in_ready[m]); end
        end
        tick();
        for (int m = 0; m < 2; m++) begin
            checks++; if (in_ready[m] !== 1'b1) begin failures++; $display("FAIL release_after_edge dut%0d got %b want 1", m, in_ready[m]); end
        end
    endtask

    task automatic test_streaming();
        out_ready = 2'b11; flush = 2'b00;
        for (int i = 1; i <= 17; i++) begin
            if (i > 1) begin
                for (int m = 0; m < 2; m++) begin
                    checks++; if (out_valid[m] !== 1'b1) begin failures++; $display("FAIL stream_valid dut%0d beat %0d got %b want 1", m, i-1, out_valid[m]); end
                    checks++; if (out_payload[m] !== W'(i-1)) begin failures++; $display("FAIL stream_payload dut%0d got %h want %h", m, out_payload[m], W'(i-1)); end
                    checks++; if (occupancy[m] !== 2'd1) begin failures++; $display("FAIL stream_occupancy dut%0d got %0d want 1", m, occupancy[m]); end
                end
            end
            if (i <= 16) begin
                in_valid = 2'b11; in_payload[0] = W'(i); in_payload[1] = W'(i);
                #1;
                for (int m = 0; m < 2; m++) begin
                    checks++; if (in_ready[m] !== 1'b1) begin failures++; $display("FAIL stream_in_ready dut%0d beat %0d got %b want 1", m, i, in_ready[m]); end
                end
            end else begin
                in_valid = 2'b00;
            end
            tick();
        end
        for (int m = 0; m < 2; m++) begin
            checks++; if (out_valid[m] !== 1'b0) begin failures++; $display("FAIL stream_drain_valid dut%0d got %b want 0", m, out_valid[m]); end
            checks++; if (out_payload[m] !== 16'h0) begin failures++; $display("FAIL stream_drain_payload dut%0d got %h want 0000", m, out_payload[m]); end
            checks++; if (occupancy[m] !== 2'd0) begin failures++; $display("FAIL stream_drain_occupancy dut%0d got %0d want 0", m, occupancy[m]); end
        end
    endtask

    task automatic test_stall_skid();
        in_valid = 2'b00; out_ready = 2'b00; flush = 2'b00;
        in_valid[1] = 1'b1; in_payload[1] = 16'h0011;
        tick();
        checks++; if (out_payload[1] !== 16'h0011) begin failures++; $display("FAIL skid_first got %h want 0011", out_payload[1]); end
        checks++; if (in_ready[1] !== 1'b1) begin failures++; $display("FAIL skid_ready_full got %b want 1", in_ready[1]); end
        in_payload[1] = 16'h0022;
        tick();
        checks++; if (out_payload[1] !== 16'h0011) begin failures++; $display("FAIL skid_hold got %h want 0011", out_payload[1]); end
        checks++; if (occupancy[1] !== 2'd2) begin failures++; $display("FAIL skid_occupancy got %0d want 2", occupancy[1]); end
        checks++; if (in_ready[1] !== 1'b0) begin failures++; $display("FAIL skid_ready_low got %b want 0", in_ready[1]); end
        in_payload[1] = 16'h0033;
        tick();
        checks++; if (out_payload[1] !== 16'h0011 || out_valid[1] !== 1'b1) begin failures++; $display("FAIL skid_still_held got %h/%b want 0011/1", out_payload[1], out_valid[1]); end
        checks++; if (occupancy[1] !== 2'd2) begin failures++; $display("FAIL skid_33_not_taken got occupancy %0d want 2", occupancy[1]); end
        out_ready[1] = 1'b1;
        #1;
        checks++; if (in_ready[1] !== 1'b0) begin failures++; $display("FAIL skid_ready_registered got %b want 0", in_ready[1]); end
        tick();
        checks++; if (out_payload[1] !== 16'h0022) begin failures++; $display("FAIL skid_second got %h want 0022", out_payload[1]); end
        checks++; if (in_ready[1] !== 1'b1) begin failures++; $display("FAIL skid_ready_back got %b want 1", in_ready[1]); end
        tick();
        checks++; if (out_payload[1] !== 16'h0033 || out_valid[1] !== 1'b1) begin failures++; $display("FAIL skid_third got %h/%b want 0033/1", out_payload[1], out_valid[1]); end
        in_valid[1] = 1'b0;
        tick();
        checks++; if (out_valid[1] !== 1'b0 || occupancy[1] !== 2'd0) begin failures++; $display("FAIL skid_drain got %b/%0d want 0/0", out_valid[1], occupancy[1]); end
    endtask

    task automatic test_stall_noskid();
        in_valid = 2'b00; out_ready = 2'b00; flush = 2'b00;
        in_valid[0] = 1'b1; in_payload[0] = 16'h0011;
        #1;
        checks++; if (in_ready[0] !== 1'b1) begin failures++; $display("FAIL noskid_ready_empty got %b want 1", in_ready[0]); end
        tick();
        in_payload[0] = 16'h0022;
        #1;
        checks++; if (in_ready[0] !== 1'b0) begin failures++; $display("FAIL noskid_ready_stall got %b want 0", in_ready[0]); end
        checks++; if (out_payload[0] !== 16'h0011) begin failures++; $display("FAIL noskid_first got %h want 0011", out_payload[0]); end
        tick();
        checks++; if (out_payload[0] !== 16'h0011 || occupancy[0] !== 2'd1) begin failures++; $display("FAIL noskid_hold got %h/%0d want 0011/1", out_payload[0], occupancy[0]); end
        out_ready[0] = 1'b1;
        #1;
        checks++; if (in_ready[0] !== 1'b1) begin failures++; $display("FAIL noskid_ready_comb got %b want 1", in_ready[0]); end
        tick();
        checks++; if (out_payload[0] !== 16'h0022 || occupancy[0] !== 2'd1) begin failures++; $display("FAIL noskid_swap got %h/%0d want 0022/1", out_payload[0], occupancy[0]); end
        in_valid[0] = 1'b0;
        tick();
        checks++; if (out_valid[0] !== 1'b0) begin failures++; $display("FAIL noskid_drain got %b want 0", out_valid[0]); end
    endtask

    task automatic test_flush();
        out_ready = 2'b00; flush = 2'b00; in_valid = 2'b11;
        in_payload[0] = 16'h0066; in_payload[1] = 16'h0066;
        tick();
        in_payload[0] = 16'h0077; in_payload[1] = 16'h0077;
        tick();
        checks++; if (occupancy[0] !== 2'd1 || occupancy[1] !== 2'd2) begin failures++; $display("FAIL flush_setup got %0d/%0d want 1/2", occupancy[0], occupancy[1]); end
        flush = 2'b11; in_payload[0] = 16'h0044; in_payload[1] = 16'h0044;
        #1;
        for (int m = 0; m < 2; m++) begin
            checks++; if (in_ready[m] !== 1'b0) begin failures++; $display("FAIL flush_in_ready dut%0d got %b want 0", m, in_ready[m]); end
        end
        tick();
        flush = 2'b00; in_valid = 2'b00; out_ready = 2'b11;
        for (int m = 0; m < 2; m++) begin
            checks++; if (out_valid[m] !== 1'b0) begin failures++; $display("FAIL flush_valid dut%0d got %b want 0", m, out_valid[m]); end
            checks++; if (out_payload[m] !== 16'h0) begin failures++; $display("FAIL flush_payload dut%0d got %h want 0000", m, out_payload[m]); end
            checks++; if (occupancy[m] !== 2'd0) begin failures++; $display("FAIL flush_occupancy dut%0d got %0d want 0", m, occupancy[m]); end
        end
        repeat (3) begin
            tick();
            for (int m = 0; m < 2; m++) begin
                checks++; if (out_valid[m] !== 1'b0) begin failures++; $display("FAIL flush_no_44 dut%0d got %b/%h want 0", m, out_valid[m], out_payload[m]); end
                checks++; if (in_ready[m] !== 1'b1) begin failures++; $display("FAIL flush_ready_after dut%0d got %b want 1", m, in_ready[m]); end
            end
        end
    endtask

    task automatic test_flush_out();
        out_ready = 2'b00; flush = 2'b00; in_valid = 2'b11;
        in_payload[0] = 16'h0055; in_payload[1] = 16'h0055;
        tick();
        in_valid = 2'b00; out_ready = 2'b11; flush = 2'b11;
        #1;
        for (int m = 0; m < 2; m++) begin
            checks++; if (out_valid[m] !== 1'b1 || out_payload[m] !== 16'h0055) begin failures++; $display("FAIL flush_out_seen dut%0d got %b/%h want 1/0055", m, out_valid[m], out_payload[m]); end
        end
        tick();
        flush = 2'b00;
        for (int m = 0; m < 2; m++) begin
            checks++; if (out_valid[m] !== 1'b0 || out_payload[m] !== 16'h0) begin failures++; $display("FAIL flush_out_after dut%0d got %b/%h want 0/0000", m, out_valid[m], out_payload[m]); end
        end
    endtask

    task automatic test_async_reset();
        out_ready = 2'b00; flush = 2'b00; in_valid = 2'b11;
        in_payload[0] = 16'h005A; in_payload[1] = 16'h005A;
        tick();
        in_valid = 2'b00;
        #2;
        reset = 1'b0;
        #1;
        for (int m = 0; m < 2; m++) begin
            checks++; if (out_valid[m] !== 1'b0 || out_payload[m] !== 16'h0) begin failures++; $display("FAIL async_reset_out dut%0d got %b/%h want 0/0000", m, out_valid[m], out_payload[m]); end
            checks++; if (occupancy[m] !== 2'd0 || in_ready[m] !== 1'b0) begin failures++; $display("FAIL async_reset_state dut%0d got occ %0d ready %b want 0/0", m, occupancy[m], in_ready[m]); end
        end
        @(negedge clk);
        reset = 1'b1;
        tick();
        for (int m = 0; m < 2; m++) begin
            checks++; if (in_ready[m] !== 1'b1) begin failures++; $display("FAIL async_release dut%0d got %b want 1", m, in_ready[m]); end
        end
    endtask

    initial begin
        flush = 2'b00; in_valid = 2'b00; out_ready = 2'b00;
        in_payload[0] = '0; in_payload[1] = '0;
        test_reset();
        test_streaming();
        test_stall_skid();
        test_stall_noskid();
        test_flush();
        test_flush_out();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_pipeline_stage_register
`default_nettype wire
